// File: rtl/expr_calc.sv
// Character-stream evaluator for single-digit expressions "d (op d)* =", where '*' binds tighter than '+'.
// Optional feature macro: EXPR_CALC_SUB_EN adds '-' as an operator at '+' precedence.
module expr_calc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       in,
  input  logic             in_valid,
  output logic             ok,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NUM  = 2'd1,
    ST_OP   = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CL_DIG = 2'd0,
    CL_OP  = 2'd1,
    CL_EQ  = 2'd2,
    CL_BAD = 2'd3
  } cls_t;

  function automatic cls_t classify(input logic [7:0] ch);
    cls_t c;
    if ((ch >= 8'h30) && (ch <= 8'h39)) begin
      c = CL_DIG;
    end else if ((ch == 8'h2B) || (ch == 8'h2A)) begin
      c = CL_OP;
`ifdef EXPR_CALC_SUB_EN
    end else if (ch == 8'h2D) begin
      c = CL_OP;
`endif
    end else if (ch == 8'h3D) begin
      c = CL_EQ;
    end else begin
      c = CL_BAD;
    end
    return c;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             mul_q, mul_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             ok_q, ok_d;

  cls_t             cls_s;
  logic [WIDTH-1:0] digit_s;
  logic [WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] addend_s;
  logic [WIDTH-1:0] sum_plus_s;

  assign cls_s   = classify(in);
  // ASCII '0'..'9' carry their value in the low nibble.
  assign digit_s = {{(WIDTH-4){1'b0}}, in[3:0]};
  assign prod_s  = term_q * digit_s;

`ifdef EXPR_CALC_SUB_EN
  logic neg_q, neg_d;
  assign addend_s = neg_q ? ({WIDTH{1'b0}} - term_q) : term_q;
`else
  assign addend_s = term_q;
`endif

  assign sum_plus_s = sum_q + addend_s;

  // Grammar sequencing and accumulator next-state.
  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    term_d   = term_q;
    mul_d    = mul_q;
    result_d = result_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
`ifdef EXPR_CALC_SUB_EN
    neg_d    = neg_q;
`endif
    if (in_valid) begin
      if (cls_s == CL_EQ) begin
        state_d = ST_IDLE;
        sum_d   = {WIDTH{1'b0}};
        term_d  = {WIDTH{1'b0}};
        mul_d   = 1'b0;
`ifdef EXPR_CALC_SUB_EN
        neg_d   = 1'b0;
`endif
        done_d  = 1'b1;
        if (state_q == ST_NUM) begin
          result_d = sum_plus_s;
          error_d  = 1'b0;
        end else begin
          error_d  = 1'b1;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cls_s == CL_DIG) begin
              state_d = ST_NUM;
              term_d  = digit_s;
              sum_d   = {WIDTH{1'b0}};
            end else begin
              state_d = ST_ERR;
            end
          end
          ST_NUM: begin
            if (cls_s == CL_OP) begin
              state_d = ST_OP;
              if (in == 8'h2A) begin
                mul_d = 1'b1;
              end else begin
                // Additive operator closes the current product into the sum.
                sum_d = sum_plus_s;
                mul_d = 1'b0;
`ifdef EXPR_CALC_SUB_EN
                neg_d = (in == 8'h2D);
`endif
              end
            end else begin
              state_d = ST_ERR;
            end
          end
          ST_OP: begin
            if (cls_s == CL_DIG) begin
              state_d = ST_NUM;
              term_d  = mul_q ? prod_s : digit_s;
            end else begin
              state_d = ST_ERR;
            end
          end
          ST_ERR: begin
            state_d = ST_ERR;
          end
          default: begin
            state_d = ST_ERR;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
    ok_d = (state_d == ST_NUM);
  end

  // State, accumulator and output registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= ST_IDLE;
      sum_q    <= {WIDTH{1'b0}};
      term_q   <= {WIDTH{1'b0}};
      mul_q    <= 1'b0;
      result_q <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      ok_q     <= 1'b0;
`ifdef EXPR_CALC_SUB_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      term_q   <= term_d;
      mul_q    <= mul_d;
      result_q <= result_d;
      done_q   <= done_d;
      error_q  <= error_d;
      ok_q     <= ok_d;
`ifdef EXPR_CALC_SUB_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign ok     = ok_q;
  assign done   = done_q;
  assign error  = error_q;
  assign result = result_q;

endmodule

// File: tb/tb_expr_calc.sv
// Bench for expr_calc: a string-level expression model checked every cycle, plus literal expectations.
module tb_expr_calc;

  logic        clk;
  logic        clr;
  logic [7:0]  in;
  logic        in_valid;
  logic        ok;
  logic        done;
  logic        error;
  logic [15:0] result;

  expr_calc #(.WIDTH(16)) dut (
    .clk      (clk),
    .clr      (clr),
    .in       (in),
    .in_valid (in_valid),
    .ok       (ok),
    .done     (done),
    .error    (error),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit started  = 1'b0;

  byte         expr_q[$];
  logic        exp_ok   = 1'b0;
  logic        exp_done = 1'b0;
  logic        exp_err  = 1'b0;
  logic [15:0] exp_res  = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit is_dig(input byte c);
    return (c >= "0") && (c <= "9");
  endfunction

  function automatic bit is_op(input byte c);
`ifdef EXPR_CALC_SUB_EN
    return (c == "+") || (c == "*") || (c == "-");
`else
    return (c == "+") || (c == "*");
`endif
  endfunction

  // A prefix is a complete expression when digits and operators strictly alternate, ending on a digit.
  function automatic bit complete_expr();
    if ((expr_q.size() == 0) || (expr_q.size() % 2 == 0)) return 1'b0;
    for (int i = 0; i < expr_q.size(); i++) begin
      if ((i % 2 == 0) && !is_dig(expr_q[i])) return 1'b0;
      if ((i % 2 == 1) && !is_op(expr_q[i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Sum of signed products, reduced modulo 2^16 at the end.
  function automatic logic [15:0] evaluate();
    longint total = 0;
    longint sgn   = 1;
    longint prod  = longint'(expr_q[0] - "0");
    for (int i = 1; i + 1 < expr_q.size(); i += 2) begin
      longint d = longint'(expr_q[i+1] - "0");
      if (expr_q[i] == "*") begin
        prod = (prod * d) & 64'hFFFF;
      end else begin
        total = total + sgn * prod;
        sgn   = (expr_q[i] == "-") ? -1 : 1;
        prod  = d;
      end
    end
    total = total + sgn * prod;
    return total[15:0];
  endfunction

  task automatic model_consume(input byte c);
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (c == "=") begin
      exp_done = 1'b1;
      if (complete_expr()) exp_res = evaluate();
      else exp_err = 1'b1;
      expr_q.delete();
    end else begin
      expr_q.push_back(c);
    end
    exp_ok = complete_expr();
  endtask

  task automatic step(input bit v, input byte c);
    @(negedge clk);
    in_valid = v;
    in       = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (v) model_consume(c);
    else begin
      exp_done = 1'b0;
      exp_err  = 1'b0;
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
  endtask

  task automatic do_clr();
    @(negedge clk);
    #2 clr = 1'b1;
    #1 check("ok_during_clr", {31'd0, ok}, 32'd0);
    #1 clr = 1'b0;
    expr_q.delete();
    exp_ok   = 1'b0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_res  = 16'd0;
    check("ok_after_clr", {31'd0, ok}, 32'd0);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (started && !clr) begin
      check("cyc_ok",     {31'd0, ok},     {31'd0, exp_ok});
      check("cyc_done",   {31'd0, done},   {31'd0, exp_done});
      check("cyc_error",  {31'd0, error},  {31'd0, exp_err});
      check("cyc_result", {16'd0, result}, {16'd0, exp_res});
    end
  end

  initial begin
    clr      = 1'b1;
    in       = 8'h00;
    in_valid = 1'b0;
    #12 clr  = 1'b0;
    check("rst_ok",     {31'd0, ok},     32'd0);
    check("rst_done",   {31'd0, done},   32'd0);
    check("rst_error",  {31'd0, error},  32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    started = 1'b1;

    step(1'b1, "1"); check("ok_1", {31'd0, ok}, 32'd1);
    step(1'b1, "+"); check("ok_plus", {31'd0, ok}, 32'd0);
    step(1'b1, "2"); check("ok_2", {31'd0, ok}, 32'd1);
    step(1'b1, "*"); check("ok_star", {31'd0, ok}, 32'd0);
    step(1'b1, "3"); check("ok_3", {31'd0, ok}, 32'd1);
    step(1'b1, "=");
    check("e1_done", {31'd0, done}, 32'd1);
    check("e1_err",  {31'd0, error}, 32'd0);
    check("e1_res",  {16'd0, result}, 32'd7);
    step(1'b0, 8'h00);
    check("e1_done_pulse", {31'd0, done}, 32'd0);

    send_str("2*3*4+5=");
    check("e2_res", {16'd0, result}, 32'd29);
    send_str("1++2=");
    check("e3_done", {31'd0, done}, 32'd1);
    check("e3_err",  {31'd0, error}, 32'd1);
    check("e3_res",  {16'd0, result}, 32'd29);

    send_str("9*9*9*9*9*9=");
    check("e4_err", {31'd0, error}, 32'd0);
    check("e4_res", {16'd0, result}, 32'd7153);
    send_str("a=");
    check("e5_err", {31'd0, error}, 32'd1);
    check("e5_res", {16'd0, result}, 32'd7153);

    send_str("1+");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, "7");
      check("gap_done", {31'd0, done}, 32'd0);
    end
    send_str("2=");
    check("e6_res", {16'd0, result}, 32'd3);
    send_str("=");
    check("e7_done", {31'd0, done}, 32'd1);
    check("e7_err",  {31'd0, error}, 32'd1);

    send_str("3*4");
    check("pre_clr_ok", {31'd0, ok}, 32'd1);
    do_clr();
    check("clr_result", {16'd0, result}, 32'd0);
    send_str("5=");
    check("e8_res", {16'd0, result}, 32'd5);

    send_str("2-3*4=");
    check("e9_done", {31'd0, done}, 32'd1);
`ifdef EXPR_CALC_SUB_EN
    check("e9_err", {31'd0, error}, 32'd0);
    check("e9_res", {16'd0, result}, 32'h0000FFF6);
`else
    check("e9_err", {31'd0, error}, 32'd1);
    check("e9_res", {16'd0, result}, 32'd5);
`endif
    send_str("8*");
    check("ok_after_op", {31'd0, ok}, 32'd0);
    send_str("9=");
    check("e10_res", {16'd0, result}, 32'd72);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/expr_calc.md
# expr_calc

Character-stream expression evaluator. Consumes one ASCII character per accepted cycle, checks syntax of single-digit expressions of the form `digit (op digit)* '='`, and evaluates them with `*` binding tighter than `+`. It is the sequencing controller that sits behind the character recognizer: it tracks the grammar state and also drives the sum/term accumulation datapath, then reports a result on `'='`.

## Interface
- `WIDTH`, default 16: width of the result and the accumulators. Arithmetic is modulo 2^WIDTH.
- `clk`, input, 1 bit: the single clock. All state updates on the rising edge.
- `clr`, input, 1 bit: asynchronous, active-high reset.
- `in`, input, 8 bits: ASCII character.
- `in_valid`, input, 1 bit: `in` is consumed on a rising edge where `in_valid`=1.
- `ok`, output, 1 bit: the prefix consumed so far is a complete valid expression (state NUM).
- `done`, output, 1 bit: one-cycle pulse when a `'='` has been consumed.
- `error`, output, 1 bit: qualifies `done`; 1 means a syntax error, and `result` is not updated.
- `result`, output, WIDTH bits: the last successfully evaluated value.

## Operation
- Character classes:
  - DIG: `'0'`..`'9'`, with value d = in−`'0'`.
  - OP: `'+'` or `'*'`.
  - EQ: `'='`.
  - BAD: anything else.
- Registers:
  - `state`: IDLE, NUM, OP, ERR.
  - `sum`, `term`: WIDTH bits each.
  - `mul`: 1 bit; the last operator was `*`.
- Transitions on an accepted character:
  - IDLE, DIG → NUM. Sets term=d, sum=0.
  - NUM, OP → OP. On `'+'`: sum=sum+term, mul=0. On `'*'`: mul=1.
  - OP, DIG → NUM. term = mul ? term*d : d.
  - NUM, EQ → IDLE. result=sum+term; done=1, error=0. Clears sum, term and mul.
  - EQ in IDLE, OP or ERR → IDLE. done=1, error=1; result is held. Clears sum, term and mul.
  - Any other character in IDLE, NUM or OP → ERR.
  - ERR absorbs every non-EQ character.
- Products and sums are truncated to WIDTH bits.
- Digit followed by digit is a syntax error; multi-digit numbers are not supported.

## Timing
- Reset values: state=IDLE, sum=0, term=0, mul=0, result=0, done=0, error=0, ok=0.
- `clr` takes effect immediately, regardless of `clk`. A partially consumed expression is discarded.
- `in_valid`=0 on an edge: every register holds, and `done`/`error` are 0 for that cycle.
- Latency: `done`/`error`/`result` are registered. They become visible in the cycle after the edge that consumed `'='`.
- `done` is high for exactly one cycle. `error` is only ever high while `done` is high.
- `ok` is a function of the state register only.
- Back-to-back expressions are allowed. A character following `'='` on the very next edge starts a new expression without a bubble.
- Characters may arrive with arbitrary `in_valid` gaps; the gaps have no effect on the result.

## Configuration
- `EXPR_CALC_SUB_EN` defined:
  - `'-'` is an additional OP of additive precedence, handled with a sign flag `neg`.
  - On `'+'` or `'-'`: sum = sum + (neg ? −term : term), and neg = (in==`'-'`).
  - On `'='`: result = sum ± term.
  - `neg` is cleared wherever `mul` is cleared.
  - Wrap is two's complement modulo 2^WIDTH.
- Macro not defined:
  - `'-'` is BAD and leads to ERR.
  - No `neg` register exists.

## Test plan
- `"1+2*3="` after reset → `done`=1, `error`=0, `result`=7 one cycle after `'='`. `ok`=1 after each digit and 0 after `'+'` and `'*'`.
- `"2*3*4+5="` back-to-back with no gaps → `result`=29. Then `"1++2="` → `done`=1, `error`=1, `result` stays 29.
- WIDTH=16, `"9*9*9*9*9*9="` → `result`=7153 (531441 mod 65536). Then `"a="` → `error`=1.
- `"1+"`, then 3 cycles with `in_valid`=0, then `"2="` → `result`=3, with `done` low during the gap. `"="` alone → `error`=1.
- `"3*4"` followed by a `clr` pulse between edges, then `"5="` → `result`=5 and `ok` reads 0 immediately after `clr`.
- With `EXPR_CALC_SUB_EN` defined, `"2-3*4="` → `result`=16'hFFF6 (65526). Without the macro, the same stimulus → `error`=1.
